// File: rtl/ga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ga_pkg
//  Purpose  : Shared types for the GA coprocessor request/response protocol.
//  Revision : 1.0 - initial release
// ============================================================================
package ga_pkg;

  localparam int unsigned GA_MV_WIDTH              = 64;
  localparam int unsigned GA_ISSUE_TIMEOUT_DEFAULT = 256;

  typedef logic [GA_MV_WIDTH-1:0] ga_multivector_t;

  typedef enum logic [3:0] {
    GA_FUNCT_ADD     = 4'd0,
    GA_FUNCT_SUB     = 4'd1,
    GA_FUNCT_MUL     = 4'd2,
    GA_FUNCT_WEDGE   = 4'd3,
    GA_FUNCT_DOT     = 4'd4,
    GA_FUNCT_REVERSE = 4'd5,
    GA_FUNCT_DUAL    = 4'd6,
    GA_FUNCT_NORM    = 4'd7
  } ga_funct_e;

  typedef struct packed {
    logic            valid;
    ga_funct_e       funct;
    ga_multivector_t operand_a;
    ga_multivector_t operand_b;
    logic [4:0]      reg_a;
    logic [4:0]      reg_b;
    logic [4:0]      rd;
    logic            we;
    logic            use_ga_regs;
  } ga_req_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    ga_multivector_t result;
    logic            error;
    logic            overflow;
    logic            underflow;
  } ga_resp_t;

  typedef enum logic [2:0] {
    GA_ISSUE_IDLE  = 3'd0,
    GA_ISSUE_REQ   = 3'd1,
    GA_ISSUE_WAIT  = 3'd2,
    GA_ISSUE_RESP  = 3'd3,
    GA_ISSUE_DRAIN = 3'd4
  } ga_issue_state_e;

  // Result record handed back to the core once an operation completes.
  typedef struct packed {
    logic            valid;
    ga_multivector_t result;
    logic            error;
    logic            timeout;
    logic            overflow;
    logic            underflow;
  } ga_issue_result_t;

endpackage
`default_nettype wire

// File: rtl/ga_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ga_issue_unit
//  Purpose  : Core-side initiator for GA coprocessor operations: one request
//             outstanding, response timeout and flush/drain handling.
//  Revision : 1.0 - initial release
// ============================================================================
module ga_issue_unit
  import ga_pkg::*;
#(
  parameter int unsigned TimeoutCycles = GA_ISSUE_TIMEOUT_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  ga_funct_e       issue_funct_i,
  input  ga_multivector_t issue_operand_a_i,
  input  ga_multivector_t issue_operand_b_i,
  input  logic [4:0]      issue_reg_a_i,
  input  logic [4:0]      issue_reg_b_i,
  input  logic [4:0]      issue_rd_i,
  input  logic            issue_we_i,
  input  logic            issue_use_ga_regs_i,
  input  logic            flush_i,
  output ga_req_t         ga_req_o,
  input  ga_resp_t        ga_resp_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output ga_multivector_t result_o,
  output logic            result_error_o,
  output logic            result_timeout_o,
  output logic            result_overflow_o,
  output logic            result_underflow_o,
  output logic            busy_o
);

  localparam int unsigned        c_cnt_w      = $clog2(TimeoutCycles + 1);
  localparam logic [c_cnt_w-1:0] c_timeout_m1 = c_cnt_w'(TimeoutCycles - 1);

  ga_issue_state_e    r_state, w_state_d;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic               w_timeout;
  ga_req_t            r_req, w_req_d;
  ga_issue_result_t   r_res, w_res_d, w_res_resp, w_res_to;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= GA_ISSUE_IDLE;
    else         r_state <= w_state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_req <= '0;
      r_res <= '0;
    end else begin
      r_cnt <= w_cnt_d;
      r_req <= w_req_d;
      r_res <= w_res_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_cnt_inc  = r_cnt + 1'b1;
    w_cnt_d    = r_cnt;
    w_req_d    = r_req;
    w_res_d    = r_res;
    // The edge that ends this cycle is the one on which the count reaches the limit.
    w_timeout  = (r_cnt >= c_timeout_m1);
    w_res_resp = '{valid: 1'b1, result: ga_resp_i.result, error: ga_resp_i.error,
                   timeout: 1'b0, overflow: ga_resp_i.overflow,
                   underflow: ga_resp_i.underflow};
    w_res_to   = '{valid: 1'b1, result: '0, error: 1'b1, timeout: 1'b1,
                   overflow: 1'b0, underflow: 1'b0};

    unique case (r_state)
      GA_ISSUE_IDLE: begin
        if (issue_valid_i && !flush_i) begin
          w_req_d = '{valid: 1'b1, funct: issue_funct_i,
                      operand_a: issue_operand_a_i, operand_b: issue_operand_b_i,
                      reg_a: issue_reg_a_i, reg_b: issue_reg_b_i, rd: issue_rd_i,
                      we: issue_we_i, use_ga_regs: issue_use_ga_regs_i};
          w_cnt_d   = '0;
          w_state_d = GA_ISSUE_REQ;
        end
      end
      GA_ISSUE_REQ: begin
        if (flush_i) begin
          w_req_d.valid = 1'b0;
          w_state_d     = GA_ISSUE_IDLE;
        end else begin
          w_cnt_d = w_cnt_inc;
          if (ga_resp_i.ready && ga_resp_i.valid) begin
            w_req_d.valid = 1'b0;
            w_res_d       = w_res_resp;
            w_state_d     = GA_ISSUE_RESP;
          end else if (w_timeout) begin
            w_req_d.valid = 1'b0;
            w_res_d       = w_res_to;
            w_state_d     = GA_ISSUE_RESP;
          end else if (ga_resp_i.ready) begin
            w_req_d.valid = 1'b0;
            w_state_d     = GA_ISSUE_WAIT;
          end
        end
      end
      GA_ISSUE_WAIT: begin
        w_cnt_d = w_cnt_inc;
        if (flush_i) begin
          w_state_d = GA_ISSUE_DRAIN;
        end else if (ga_resp_i.valid) begin
          w_res_d   = w_res_resp;
          w_state_d = GA_ISSUE_RESP;
        end else if (w_timeout) begin
          w_res_d   = w_res_to;
          w_state_d = GA_ISSUE_RESP;
        end
      end
      GA_ISSUE_RESP: begin
        if (flush_i || result_ready_i) begin
          w_res_d.valid = 1'b0;
          w_state_d     = GA_ISSUE_IDLE;
        end
      end
      GA_ISSUE_DRAIN: begin
        w_cnt_d = w_cnt_inc;
        if (ga_resp_i.valid || w_timeout) w_state_d = GA_ISSUE_IDLE;
      end
      default: w_state_d = GA_ISSUE_IDLE;
    endcase
  end

  assign issue_ready_o      = (r_state == GA_ISSUE_IDLE) && !flush_i;
  assign busy_o             = (r_state != GA_ISSUE_IDLE);
  assign ga_req_o           = r_req;
  assign result_valid_o     = r_res.valid;
  assign result_o           = r_res.result;
  assign result_error_o     = r_res.error;
  assign result_timeout_o   = r_res.timeout;
  assign result_overflow_o  = r_res.overflow;
  assign result_underflow_o = r_res.underflow;

endmodule
`default_nettype wire
